adder_operand_sequencer: RTL and testbench

Controller that owns the write/read port of the 8×4-bit operand register file feeding the 16-bit ripple-carry adder. On a start request it loads two 16-bit operands as eight nibble writes, optionally reads them back to verify, waits for the ripple chain to settle, then captures the 16-bit sum and carry-out. It replaces the manual switch/button loading path with a system-clock-driven sequencer, so a host or test FSM can issue whole additions.

---
 rtl/adder_operand_sequencer_pkg.sv | 28 ++
 rtl/adder_operand_sequencer.sv | 157 +++++++++++++++
 tb/tb_adder_operand_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/adder_operand_sequencer_pkg.sv
// Shared definitions for the adder operand sequencer.
// Holds the sequencer state encoding, the register-file geometry and the
// nibble-select helper used to walk the latched operand pair.
package adder_operand_sequencer_pkg;

  localparam int unsigned NIBBLES = 8;
  localparam int unsigned A_BASE  = 0;
  localparam int unsigned B_BASE  = 4;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned NIB_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    VERIFY,
    SETTLE,
    CAPTURE
  } seq_state_e;

  // Nibble k of the latched operand pair; addr 0-3 = op_a, addr 4-7 = op_b.
  function automatic logic [NIB_W-1:0] nib_sel(
    input logic [NIBBLES*NIB_W-1:0] ops,
    input logic [ADDR_W-1:0]        k
  );
    return ops[32'(k)*NIB_W +: NIB_W];
  endfunction

endpackage

// File: rtl/adder_operand_sequencer.sv
// Sequencer driving the 8x4-bit operand register file in front of the
// 16-bit ripple-carry adder. A start request latches two operands, writes
// them as eight nibbles, optionally reads them back, waits for the adder
// to settle and captures sum / carry-out.
//
// Ports:
//   clk, reset        system clock, asynchronous active-low reset
//   start             request an addition (sampled only when idle)
//   op_a, op_b        16-bit operands, latched on accept
//   busy, done        operation in flight / one-cycle result-valid pulse
//   sum, cout         captured adder result and carry-out
//   verify_err        sticky read-back mismatch flag for current operation
//   rf_rw, rf_data,
//   rf_addr           register file write/read port
//   rf_read_value     register file combinational read data
//   add_sout,
//   add_cout          adder outputs computed from register file contents
module adder_operand_sequencer
  import adder_operand_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          VERIFY_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] sum,
  output logic        cout,
  output logic        verify_err,
  output logic        rf_rw,
  output logic [3:0]  rf_data,
  output logic [2:0]  rf_addr,
  input  logic [3:0]  rf_read_value,
  input  logic [15:0] add_sout,
  input  logic        add_cout
);

  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NIBBLES - 1);
  localparam logic [15:0]       SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  // Phase skipping is resolved at elaboration time from the parameters.
  localparam seq_state_e AFTER_VERIFY = (SETTLE_CYCLES > 0) ? SETTLE : CAPTURE;
  localparam seq_state_e AFTER_WRITE  = VERIFY_EN ? VERIFY : AFTER_VERIFY;

  seq_state_e               state_q, state_d;
  logic [ADDR_W-1:0]        idx_q, idx_d;
  logic [15:0]              settle_q, settle_d;
  logic [NIBBLES*NIB_W-1:0] ops_q;
  logic [15:0]              sum_q;
  logic                     cout_q;
  logic                     done_q;
  logic                     verr_q;
  logic                     accept;
  logic                     verr_set;
  logic                     capture;
  logic [NIB_W-1:0]         cur_nib;

  assign cur_nib = nib_sel(ops_q, idx_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      ops_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
      verr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      done_q   <= capture;
      if (accept) begin
        ops_q[A_BASE*NIB_W +: 16] <= op_a;
        ops_q[B_BASE*NIB_W +: 16] <= op_b;
        verr_q                    <= 1'b0;
      end else if (verr_set) begin
        verr_q <= 1'b1;
      end
      if (capture) begin
        sum_q  <= add_sout;
        cout_q <= add_cout;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    rf_rw    = 1'b0;
    rf_addr  = '0;
    rf_data  = '0;
    accept   = 1'b0;
    verr_set = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_d  = WRITE;
          idx_d    = '0;
          settle_d = '0;
        end
      end
      WRITE: begin
        rf_rw   = 1'b1;
        rf_addr = idx_q;
        rf_data = cur_nib;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = AFTER_WRITE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      VERIFY: begin
        rf_addr = idx_q;
        // Mismatch only flags; the operation still runs to completion.
        if (rf_read_value != cur_nib) verr_set = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = AFTER_VERIFY;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SETTLE: begin
        rf_addr = LAST_IDX;
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = CAPTURE;
        end else begin
          settle_d = settle_q + 16'd1;
        end
      end
      CAPTURE: begin
        capture = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign sum        = sum_q;
  assign cout       = cout_q;
  assign verify_err = verr_q;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Self-checking bench for adder_operand_sequencer. Two instances: default
// parameters and a no-verify / no-settle variant. Each has its own model of
// the register file and adder; expected results come from plain arithmetic
// on the operands.
module tb_adder_operand_sequencer;

  logic clk = 1'b0;
  logic reset;

  logic        start0, start1;
  logic [15:0] a0, b0, a1, b1;
  logic        busy0, done0, cout0, verr0, rw0;
  logic        busy1, done1, cout1, verr1, rw1;
  logic [15:0] sum0, sum1;
  logic [3:0]  wd0, wd1, rd0, rd1;
  logic [2:0]  ad0, ad1;
  logic [16:0] add0, add1;

  logic [3:0]  mem0 [8];
  logic [3:0]  mem1 [8];
  logic        corrupt0;
  logic [6:0]  wq0 [$];
  logic [6:0]  wq1 [$];

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        cout;
    logic        verr;
    logic        rw;
    logic [2:0]  addr;
    logic [3:0]  data;
    logic [15:0] sum;
  } stat_t;

  initial forever #5 clk = ~clk;

  adder_operand_sequencer u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .op_a(a0), .op_b(b0),
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .verify_err(verr0),
    .rf_rw(rw0), .rf_data(wd0), .rf_addr(ad0), .rf_read_value(rd0),
    .add_sout(add0[15:0]), .add_cout(add0[16])
  );

  adder_operand_sequencer #(.SETTLE_CYCLES(0), .VERIFY_EN(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .op_a(a1), .op_b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .verify_err(verr1),
    .rf_rw(rw1), .rf_data(wd1), .rf_addr(ad1), .rf_read_value(rd1),
    .add_sout(add1[15:0]), .add_cout(add1[16])
  );

  // Register file + ripple adder environment.
  always @(posedge clk) if (rw0) mem0[ad0] <= wd0;
  always @(posedge clk) if (rw1) mem1[ad1] <= wd1;
  assign rd0  = mem0[ad0] ^ ((corrupt0 && !rw0 && ad0 == 3'd5) ? 4'hF : 4'h0);
  assign rd1  = mem1[ad1];
  assign add0 = {1'b0, mem0[7], mem0[6], mem0[5], mem0[4]}
              + {1'b0, mem0[3], mem0[2], mem0[1], mem0[0]};
  assign add1 = {1'b0, mem1[7], mem1[6], mem1[5], mem1[4]}
              + {1'b0, mem1[3], mem1[2], mem1[1], mem1[0]};

  always @(negedge clk) if (rw0) wq0.push_back({ad0, wd0});
  always @(negedge clk) if (rw1) wq1.push_back({ad1, wd1});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic stat_t st(input int d);
    stat_t s;
    if (d == 0) s = '{busy0, done0, cout0, verr0, rw0, ad0, wd0, sum0};
    else        s = '{busy1, done1, cout1, verr1, rw1, ad1, wd1, sum1};
    return s;
  endfunction

  task automatic set_start(input int d, input logic s, input logic [15:0] a, input logic [15:0] b);
    if (d == 0) begin start0 = s; a0 = a; b0 = b; end
    else        begin start1 = s; a1 = a; b1 = b; end
  endtask

  // Called at posedge+1 with the selected DUT idle; returns at posedge+1
  // of the cycle in which done is (expected) high.
  task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                        input bit corrupt, input int poke_at,
                        input logic [15:0] pa, input logic [15:0] pb);
    int          exp_lat;
    logic [16:0] exp_sum;
    logic [3:0]  nib;
    logic [6:0]  got_w;
    int          n;
    int          qs;
    bit          seen;
    stat_t       s;
    exp_lat = (d == 0) ? 19 : 9;
    exp_sum = {1'b0, a} + {1'b0, b};
    s = st(d);
    chk($sformatf("d%0d_idle_busy", d), 32'(s.busy), 0);
    if (d == 0) begin wq0.delete(); corrupt0 = corrupt; end
    else        wq1.delete();
    set_start(d, 1'b1, a, b);
    @(posedge clk); #1;
    set_start(d, 1'b0, pa, pb);
    s = st(d);
    chk($sformatf("d%0d_accept_busy", d), 32'(s.busy), 1);
    chk($sformatf("d%0d_accept_done_low", d), 32'(s.done), 0);
    chk($sformatf("d%0d_accept_verr_clr", d), 32'(s.verr), 0);
    n = 0;
    seen = 0;
    while (n < 60 && !seen) begin
      set_start(d, (poke_at != 0 && n == poke_at), pa, pb);
      @(posedge clk); #1;
      n++;
      s = st(d);
      if (s.done) seen = 1;
    end
    set_start(d, 1'b0, pa, pb);
    chk($sformatf("d%0d_done_seen", d), 32'(seen), 1);
    chk($sformatf("d%0d_latency", d), 32'(n), 32'(exp_lat));
    chk($sformatf("d%0d_busy_at_done", d), 32'(s.busy), 0);
    chk($sformatf("d%0d_sum", d), 32'(s.sum), 32'(exp_sum[15:0]));
    chk($sformatf("d%0d_cout", d), 32'(s.cout), 32'(exp_sum[16]));
    chk($sformatf("d%0d_verr", d), 32'(s.verr), 32'(d == 0 && corrupt));
    qs = (d == 0) ? wq0.size() : wq1.size();
    chk($sformatf("d%0d_wr_count", d), 32'(qs), 8);
    for (int k = 0; k < 8 && k < qs; k++) begin
      nib   = 4'(((k < 4) ? (a >> (4 * k)) : (b >> (4 * (k - 4)))) & 16'hF);
      got_w = (d == 0) ? wq0[k] : wq1[k];
      chk($sformatf("d%0d_wr%0d", d, k), 32'(got_w), 32'({3'(k), nib}));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stat_t s;
    int    extra;
    int    d;
    logic [15:0] ra, rb;
    reset = 1'b0;
    corrupt0 = 1'b0;
    set_start(0, 1'b0, 16'h0, 16'h0);
    set_start(1, 1'b0, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      s = st(i);
      chk($sformatf("d%0d_reset_state", i), 32'(s), 0);
    end
    reset = 1'b1;
    @(posedge clk); #1;

    run_op(0, 16'h1234, 16'h4321, 0, 0, 16'h0, 16'h0);
    run_op(0, 16'hFFFF, 16'h0001, 0, 0, 16'h0, 16'h0);
    // Corrupted read-back, then back-to-back op clears the flag.
    run_op(0, 16'h0F0F, 16'h00F0, 1, 0, 16'h0, 16'h0);
    run_op(0, 16'hABCD, 16'h1111, 0, 0, 16'h0, 16'h0);

    // Second start mid-operation must be ignored.
    run_op(0, 16'h0101, 16'h0202, 0, 5, 16'h7777, 16'h8888);
    extra = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done0) extra++;
    end
    chk("d0_no_extra_done", 32'(extra), 0);

    // Reset in the middle of the write phase.
    set_start(0, 1'b1, 16'h1111, 16'h2222);
    @(posedge clk); #1;
    set_start(0, 1'b0, 16'h0, 16'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("d0_mid_write_addr", 32'(ad0), 4);
    chk("d0_mid_write_rw", 32'(rw0), 1);
    reset = 1'b0;
    #1;
    chk("d0_rst_busy", 32'(busy0), 0);
    chk("d0_rst_rw", 32'(rw0), 0);
    chk("d0_rst_sum", 32'(sum0), 0);
    chk("d0_rst_done", 32'(done0), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_op(0, 16'h0010, 16'h0020, 0, 0, 16'h0, 16'h0);

    run_op(1, 16'h8000, 16'h8000, 0, 0, 16'h0, 16'h0);

    for (int i = 0; i < 20; i++) begin
      d  = i % 2;
      ra = 16'($urandom);
      rb = 16'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      if (!clk) begin
        @(posedge clk); #1;
      end
      run_op(d, ra, rb, ($urandom_range(0, 3) == 0), 0, 16'($urandom), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
